// File: rtl/noise_ctrl_pkg.sv
// rtl/noise_ctrl_pkg.sv - shared state encoding and default sizes for the noise table loader
//
// Purpose : state enum for the table-load sequencer and the default table
//           geometry shared with the noise wrapper.
// Ports   : none (package).
package noise_ctrl_pkg;

    localparam int NOISE_TBL_DEPTH = 128;
    localparam int NOISE_ADDR_W    = 14;
    localparam int NOISE_DATA_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - read-latency shift register carrying {valid, index}
//
// Purpose : delays each issued read's valid bit and table index by DEPTH
//           cycles so the write strobe lines up with the memory data.
// Ports   : clk, rstn      - clock, asynchronous active-low reset
//           i_vld, i_idx   - issue strobe and table index entering the pipe
//           o_vld, o_idx   - registered output stage (DEPTH cycles later)
//           o_pre_vld/idx  - value that will load into the output stage next
//           o_empty        - nothing in flight behind the output stage
module rd_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_pre_vld,
    output logic [IDX_W-1:0] o_pre_idx,
    output logic             o_empty
);

    logic [DEPTH-1:0] r_vld;
    logic [IDX_W-1:0] r_idx [DEPTH];

    // Chain element 0 is the pipe input, element k+1 is stage k; this keeps
    // the DEPTH=1 case free of negative stage indices.
    logic [DEPTH:0]   w_vld_chain;
    logic [IDX_W-1:0] w_idx_chain [DEPTH+1];

    always_comb begin
        w_vld_chain[0] = i_vld;
        w_idx_chain[0] = i_idx;
        for (int k = 0; k < DEPTH; k++) begin
            w_vld_chain[k+1] = r_vld[k];
            w_idx_chain[k+1] = r_idx[k];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) r_idx[k] <= '0;
        end else begin
            r_vld <= w_vld_chain[DEPTH-1:0];
            for (int k = 0; k < DEPTH; k++) r_idx[k] <= w_idx_chain[k];
        end
    end

    assign o_vld     = r_vld[DEPTH-1];
    assign o_idx     = r_idx[DEPTH-1];
    assign o_pre_vld = w_vld_chain[DEPTH-1];
    assign o_pre_idx = w_idx_chain[DEPTH-1];
    assign o_empty   = ~|w_vld_chain[DEPTH-1:0];

endmodule

// File: rtl/noise_tbl_load_ctrl.sv
// rtl/noise_tbl_load_ctrl.sv - sequencer loading the noise table from memory port 2
//
// Purpose : reads TBL_DEPTH entries from memory port 2, writes them into the
//           noise wrapper table, then enables the noise datapath; a start in
//           RUN halts noise and reloads the table.
// Ports   : clk, rstn          - clock, asynchronous active-low reset
//           start, base_addr   - load/reload request and entry-0 address
//           mem_addr, mem_rd   - memory port-2 read request
//           mem_readdata       - memory read data (RD_LAT cycles after mem_rd)
//           tbl_wr, tbl_location, tbl_data - table write to the wrapper
//           load_done          - pulse with the final table write
//           noise_en, busy     - datapath enable, load in progress
module noise_tbl_load_ctrl
    import noise_ctrl_pkg::*;
#(
    parameter int TBL_DEPTH = NOISE_TBL_DEPTH,
    parameter int ADDR_W    = NOISE_ADDR_W,
    parameter int ADDR_STEP = 4,
    parameter int RD_LAT    = 1,
    parameter int DATA_W    = NOISE_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              tbl_wr,
    output logic [7:0]        tbl_location,
    output logic [DATA_W-1:0] tbl_data,
    output logic              load_done,
    output logic              noise_en,
    output logic              busy
);

    localparam logic [7:0]        LAST_IDX = 8'(TBL_DEPTH - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic [7:0]        r_issue_idx, w_issue_idx_nxt;
    logic              r_load_done, w_load_done_nxt;
    logic              r_noise_en;
    logic              r_busy;

    logic              w_pipe_vld, w_pipe_pre_vld, w_pipe_empty;
    logic [7:0]        w_pipe_idx, w_pipe_pre_idx;

    // The pipe is fed from the registered read strobe, so its output stage
    // becomes the registered write strobe exactly RD_LAT cycles later.
    rd_lat_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (8)
    ) u_rd_lat_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .i_vld     (r_mem_rd),
        .i_idx     (r_issue_idx),
        .o_vld     (w_pipe_vld),
        .o_idx     (w_pipe_idx),
        .o_pre_vld (w_pipe_pre_vld),
        .o_pre_idx (w_pipe_pre_idx),
        .o_empty   (w_pipe_empty)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_rd_nxt    = 1'b0;
        w_issue_idx_nxt = r_issue_idx;
        case (r_state)
            IDLE, RUN: begin
                if (start) begin
                    w_state_nxt     = LOAD;
                    w_mem_addr_nxt  = base_addr;
                    w_issue_idx_nxt = 8'd0;
                    w_mem_rd_nxt    = 1'b1;
                end
            end
            LOAD: begin
                if (r_issue_idx == LAST_IDX) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_issue_idx_nxt = r_issue_idx + 8'd1;
                    // Address wraps modulo 2^ADDR_W by design.
                    w_mem_addr_nxt  = r_mem_addr + STEP;
                    w_mem_rd_nxt    = 1'b1;
                end
            end
            DRAIN: begin
                if (r_load_done && w_pipe_empty) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Registered so the pulse coincides with the final table write.
        w_load_done_nxt = w_pipe_pre_vld && (w_pipe_pre_idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_issue_idx <= '0;
            r_load_done <= 1'b0;
            r_noise_en  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_issue_idx <= w_issue_idx_nxt;
            r_load_done <= w_load_done_nxt;
            r_noise_en  <= (w_state_nxt == RUN);
            r_busy      <= (w_state_nxt == LOAD) || (w_state_nxt == DRAIN);
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_rd       = r_mem_rd;
    assign tbl_wr       = w_pipe_vld;
    assign tbl_location = w_pipe_idx;
    assign tbl_data     = w_pipe_vld ? mem_readdata : '0;
    assign load_done    = r_load_done;
    assign noise_en     = r_noise_en;
    assign busy         = r_busy;

endmodule

// File: doc/noise_tbl_load_ctrl.md
Name: noise_tbl_load_ctrl

Overview:
Sequencer that loads the 128-entry noise distribution table from on-chip memory port 2 (64-bit) into the noise wrapper, then enables the noise datapath. It replaces the hand-driven address counter, location counter and load_mem/done_wait glue with one FSM. It supports reload on request: noise is halted, the table is rewritten, and noise resumes. It sits between NIOS_UART_on_chip_mem port 2 and noise_128_wrapper.

Parameters:
TBL_DEPTH, 128, number of table entries loaded (1..256)
ADDR_W, 14, memory port-2 address width
ADDR_STEP, 4, address increment per entry
RD_LAT, 1, memory read latency in cycles from mem_rd to valid mem_readdata (1..4)
DATA_W, 64, memory data width

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: load (or reload) the table
base_addr  in  ADDR_W  address of entry 0, sampled on an accepted start
mem_addr  out  ADDR_W  memory port-2 address
mem_rd  out  1  read strobe, one per entry
mem_readdata  in  DATA_W  memory read data
tbl_wr  out  1  table write strobe to the wrapper (load_mem)
tbl_location  out  8  table entry index for tbl_wr
tbl_data  out  DATA_W  table entry data
load_done  out  1  single-cycle pulse when the final entry has been written
noise_en  out  1  enable to the noise datapath
busy  out  1  high in LOAD or DRAIN

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE; mem_addr=0, mem_rd=0, tbl_wr=0, tbl_location=0, tbl_data=0, load_done=0, noise_en=0, busy=0; issue counter, pipeline valid bits and pipeline index bits cleared. Reset asserted mid-load aborts the load immediately; no partial-done pulse is generated.
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE: on start, latch base_addr into base_q, clear the issue counter, go to LOAD.
- LOAD: mem_rd=1 every cycle. Issue i (0..TBL_DEPTH-1) drives mem_addr = base_q + i*ADDR_STEP, truncated modulo 2^ADDR_W (wrap is legal and silent). Issue i occurs on the i-th LOAD cycle. After issue TBL_DEPTH-1, go to DRAIN.
- Response pipeline: a shift register RD_LAT deep carries {valid, index}. Issue at cycle t produces tbl_wr=1, tbl_location=i and tbl_data=mem_readdata at cycle t+RD_LAT. tbl_data is a combinational pass of mem_readdata, qualified by tbl_wr. Writes are strictly back-to-back with increasing location.
- DRAIN: mem_rd=0. Wait until the pipeline is empty. In the cycle the final tbl_wr (location TBL_DEPTH-1) is driven, load_done=1. Next cycle: state=RUN, noise_en=1.
- RUN: noise_en=1 and held. A start in RUN gives noise_en=0 in the next cycle, latches the new base, and enters LOAD (reload).
- A start in LOAD or DRAIN is ignored; there is no queueing.
- busy=1 exactly while in LOAD or DRAIN.
- A total load takes TBL_DEPTH+RD_LAT cycles from the first mem_rd to load_done inclusive (129 cycles with the defaults).
- All outputs except tbl_data are registered.

Decomposition:
- Package noise_ctrl_pkg: state enum (IDLE, LOAD, DRAIN, RUN); localparams for the default TBL_DEPTH, ADDR_W and DATA_W, shared with noise_128_wrapper.
- One sub-module, rd_lat_pipe: a parameterised RD_LAT-deep {valid, index} shift register with an empty flag.

Test Plan:
- Basic load: reset, start with base_addr=0x000 -> mem_addr 0x000,0x004,…,0x1FC over 128 cycles; tbl_wr locations 0..127 each exactly once, RD_LAT cycles later, with data matching a preloaded memory pattern; load_done one pulse; noise_en=1 the cycle after.
- Address wrap: base_addr=0x3F80, ADDR_STEP=4 -> the entry at index 32 reads address 0x0000; all 128 writes complete; noise_en=1.
- Latency sweep: RD_LAT=1,2,4 -> tbl_wr is asserted exactly RD_LAT cycles after the matching mem_rd; load_done occurs at cycle 128+RD_LAT from the first mem_rd.
- Ignored start: start pulses at LOAD cycle 10 and during DRAIN -> the sequence is unchanged; only 128 writes and one load_done.
- Reload: in RUN, start with base_addr=0x200 -> noise_en=0 the next cycle; a fresh 128-entry load from 0x200 follows; noise_en returns to 1 after load_done.
- Async reset mid-load: rstn low at LOAD cycle 50, without a clock edge -> all outputs go to 0 immediately; no load_done; after release, a new start performs a full clean load.
